sha256_stream_padder: RTL and testbench

//   Multi-block successor to the single-block padder. Reads a message of up to MAX_MESSAGE_LENGTH

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_pad_byte_gen.sv | 36 +++
 rtl/sha256_stream_padder.sv | 189 ++++++++++++++++++
 tb/tb_sha256_stream_padder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and state type for the SHA-256 stream padder.
package sha256_pkg;

  localparam int         BLOCK_BITS      = 512;
  localparam int         BLOCK_BYTES     = 64;
  localparam int         LEN_FIELD_BYTES = 8;
  localparam logic [7:0] PAD_MARKER      = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    DONE
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_byte_gen.sv
// Selects one padded byte for a block slot: message byte, 0x80 marker,
// big-endian bit-length field (final block tail) or zero.
module sha256_pad_byte_gen
  import sha256_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int P_W   = 11
) (
  input  logic [P_W-1:0]   pos_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [5:0]       slot_i,
  input  logic             last_i,
  input  logic [7:0]       mem_data_i,
  output logic [7:0]       byte_o
);

  logic [P_W-1:0] len_ext;
  logic [63:0]    bit_len;

  assign len_ext = P_W'(len_i);
  assign bit_len = 64'(len_i) << 3;

  always_comb begin
    if (pos_i < len_ext) begin
      byte_o = mem_data_i;
    end else if (pos_i == len_ext) begin
      byte_o = PAD_MARKER;
    end else if (last_i && (slot_i >= 6'(BLOCK_BYTES - LEN_FIELD_BYTES))) begin
      // slot 56 carries the most significant byte of the bit length
      byte_o = 8'(bit_len >> {3'd7 - slot_i[2:0], 3'b000});
    end else begin
      byte_o = 8'h00;
    end
  end

endmodule

// File: rtl/sha256_stream_padder.sv
// Multi-block SHA-256 padder: streams the message from SRAM into 512-bit blocks.
// Optional PAD_BLK_INFO_EN adds regop_blk_idx / regop_blk_last outputs.
//
// state | meaning
// IDLE  | waiting for main_go_sig
// FILL  | issuing SRAM reads for 64 slots, writing bytes through a 2-stage pipe
// HOLD  | block valid (regop_pad_rdy), waiting for pad_ack
// DONE  | one-cycle done pulse, then back to IDLE
module sha256_stream_padder
  import sha256_pkg::*;
#(
  parameter int MAX_MESSAGE_LENGTH = 1023,
  parameter int SYMBOL_WIDTH       = 8,
  parameter int LEN_W              = $clog2(MAX_MESSAGE_LENGTH + 1),
  parameter int ADDR_W             = $clog2(MAX_MESSAGE_LENGTH),
  parameter int BLK_W              = $clog2((MAX_MESSAGE_LENGTH + 8) / 64 + 2)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    main_go_sig,
  input  logic [LEN_W-1:0]        msg_len,
  input  logic [SYMBOL_WIDTH-1:0] msg_mem_data,
  input  logic                    pad_ack,
  output logic                    regop_msg_mem_en,
  output logic [ADDR_W-1:0]       regop_msg_mem_addr,
  output logic [BLOCK_BITS-1:0]   regop_pad_reg,
  output logic                    regop_pad_rdy,
  output logic                    regop_busy,
  output logic                    regop_done,
  output logic                    regop_len_err
`ifdef PAD_BLK_INFO_EN
  ,
  output logic [BLK_W-1:0]        regop_blk_idx,
  output logic                    regop_blk_last
`endif
);

  localparam int P_W = BLK_W + 6;

  pad_state_t            state_q;
  logic [LEN_W-1:0]      len_q;
  logic [BLK_W-1:0]      blk_q, last_blk_q;
  logic [5:0]            slot_q, slot2_q, slot3_q;
  logic                  issue_q, vld2_q, vld3_q;
  logic [7:0]            byte3_q;
  logic                  en_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BLOCK_BITS-1:0] pad_q;
  logic                  rdy_q, busy_q, done_q, len_err_q;

  logic [LEN_W:0]        len_pad_d;
  logic [BLK_W-1:0]      last_blk_d;
  logic [BLK_W-1:0]      blk_inc_d;
  logic [P_W-1:0]        pos_next_slot_d, pos_next_blk_d, pos2_d;
  logic [7:0]            byte_d;
  logic                  len_over_d;

  assign len_pad_d       = {1'b0, msg_len} + (LEN_W + 1)'(LEN_FIELD_BYTES);
  assign last_blk_d      = BLK_W'(len_pad_d >> $clog2(BLOCK_BYTES));
  assign len_over_d      = {1'b0, msg_len} > (LEN_W + 1)'(MAX_MESSAGE_LENGTH);
  assign blk_inc_d       = blk_q + BLK_W'(1);
  assign pos_next_slot_d = {blk_q, slot_q + 6'd1};
  assign pos_next_blk_d  = {blk_inc_d, 6'd0};
  assign pos2_d          = {blk_q, slot2_q};

  // slot2 is the slot whose SRAM data is on msg_mem_data this cycle
  sha256_pad_byte_gen #(
    .LEN_W(LEN_W),
    .P_W  (P_W)
  ) u_byte_gen (
    .pos_i     (pos2_d),
    .len_i     (len_q),
    .slot_i    (slot2_q),
    .last_i    (blk_q == last_blk_q),
    .mem_data_i(msg_mem_data),
    .byte_o    (byte_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      blk_q      <= '0;
      last_blk_q <= '0;
      slot_q     <= '0;
      slot2_q    <= '0;
      slot3_q    <= '0;
      issue_q    <= 1'b0;
      vld2_q     <= 1'b0;
      vld3_q     <= 1'b0;
      byte3_q    <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      pad_q      <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      vld2_q  <= issue_q;
      slot2_q <= slot_q;
      vld3_q  <= vld2_q;
      slot3_q <= slot2_q;
      byte3_q <= byte_d;
      if (vld3_q) begin
        pad_q[{~slot3_q, 3'b111} -: 8] <= byte3_q;
      end

      case (state_q)
        IDLE: begin
          if (main_go_sig) begin
            if (len_over_d) begin
              len_err_q <= 1'b1;
            end else begin
              len_err_q  <= 1'b0;
              len_q      <= msg_len;
              last_blk_q <= last_blk_d;
              blk_q      <= '0;
              slot_q     <= '0;
              issue_q    <= 1'b1;
              en_q       <= (msg_len != '0);
              addr_q     <= '0;
              pad_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= FILL;
            end
          end
        end

        FILL: begin
          if (issue_q) begin
            if (slot_q == 6'd63) begin
              issue_q <= 1'b0;
              en_q    <= 1'b0;
            end else begin
              slot_q <= slot_q + 6'd1;
              en_q   <= (pos_next_slot_d < P_W'(len_q));
              addr_q <= ADDR_W'(pos_next_slot_d);
            end
          end
          if (vld3_q && (slot3_q == 6'd63)) begin
            rdy_q   <= 1'b1;
            state_q <= HOLD;
          end
        end

        HOLD: begin
          if (pad_ack) begin
            rdy_q <= 1'b0;
            if (blk_q != last_blk_q) begin
              blk_q   <= blk_inc_d;
              slot_q  <= '0;
              issue_q <= 1'b1;
              en_q    <= (pos_next_blk_d < P_W'(len_q));
              addr_q  <= ADDR_W'(pos_next_blk_d);
              pad_q   <= '0;
              state_q <= FILL;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign regop_msg_mem_en   = en_q;
  assign regop_msg_mem_addr = addr_q;
  assign regop_pad_reg      = pad_q;
  assign regop_pad_rdy      = rdy_q;
  assign regop_busy         = busy_q;
  assign regop_done         = done_q;
  assign regop_len_err      = len_err_q;

`ifdef PAD_BLK_INFO_EN
  assign regop_blk_idx  = blk_q;
  assign regop_blk_last = rdy_q && (blk_q == last_blk_q);
`endif

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder with a byte-queue padding model.
module tb_sha256_stream_padder;

  localparam int MAX    = 1000;
  localparam int LEN_W  = $clog2(MAX + 1);
  localparam int ADDR_W = $clog2(MAX);
  localparam int BLK_W  = $clog2((MAX + 8) / 64 + 2);

  typedef logic [511:0] blk_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              main_go_sig = 1'b0;
  logic [LEN_W-1:0]  msg_len = '0;
  logic [7:0]        msg_mem_data = '0;
  logic              pad_ack = 1'b0;
  logic              regop_msg_mem_en;
  logic [ADDR_W-1:0] regop_msg_mem_addr;
  logic [511:0]      regop_pad_reg;
  logic              regop_pad_rdy, regop_busy, regop_done, regop_len_err;
`ifdef PAD_BLK_INFO_EN
  logic [BLK_W-1:0]  regop_blk_idx;
  logic              regop_blk_last;
`endif

  sha256_stream_padder #(.MAX_MESSAGE_LENGTH(MAX)) dut (
    .clock             (clock),
    .reset             (reset),
    .main_go_sig       (main_go_sig),
    .msg_len           (msg_len),
    .msg_mem_data      (msg_mem_data),
    .pad_ack           (pad_ack),
    .regop_msg_mem_en  (regop_msg_mem_en),
    .regop_msg_mem_addr(regop_msg_mem_addr),
    .regop_pad_reg     (regop_pad_reg),
    .regop_pad_rdy     (regop_pad_rdy),
    .regop_busy        (regop_busy),
    .regop_done        (regop_done),
    .regop_len_err     (regop_len_err)
`ifdef PAD_BLK_INFO_EN
    ,
    .regop_blk_idx     (regop_blk_idx),
    .regop_blk_last    (regop_blk_last)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:1023];
  always @(posedge clock) begin
    if (regop_msg_mem_en) msg_mem_data <= mem[regop_msg_mem_addr];
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  blk_t blocks[$];
  int   exp_len = 0;
  int   exp_next_addr = 0;
  int   mon_idx = 0;
  bit   mon_active = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Padded message = bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
  task automatic build_model(input int len);
    logic [7:0]  b[$];
    logic [63:0] bitlen;
    blk_t        blk;
    b = {};
    for (int i = 0; i < len; i++) b.push_back(mem[i]);
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    bitlen = 64'(len) * 64'd8;
    for (int j = 7; j >= 0; j--) b.push_back(bitlen[8*j +: 8]);
    blocks = {};
    for (int k = 0; k < b.size() / 64; k++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = b[64*k + i];
      blocks.push_back(blk);
    end
  endtask

  always @(negedge clock) begin
    if (reset && mon_active) begin
      if (regop_msg_mem_en) begin
        check("rd_addr", 512'(regop_msg_mem_addr), 512'(exp_next_addr));
        check("rd_bound", 512'(exp_next_addr < exp_len), 512'(1));
        exp_next_addr++;
      end
      if (regop_pad_rdy) begin
        if (mon_idx < blocks.size()) check("pad_block", regop_pad_reg, blocks[mon_idx]);
        else check("extra_rdy", 512'(regop_pad_rdy), 512'(0));
      end
    end
  end

  task automatic wait_rdy(input bit inject, output int n);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (inject && n == 10) pad_ack = 1'b1;
      if (inject && n == 11) pad_ack = 1'b0;
    end while (!regop_pad_rdy && n < 200);
  endtask

  task automatic start_go(input int len);
    build_model(len);
    exp_len = len;
    exp_next_addr = 0;
    mon_idx = 0;
    mon_active = 1'b1;
    @(negedge clock);
    main_go_sig = 1'b1;
    msg_len = LEN_W'(len);
    @(posedge clock);
    #1;
    main_go_sig = 1'b0;
    msg_len = '0;
  endtask

  task automatic run_msg(input int len, input int ack_delay, input bit inject);
    int n;
    int nb;
    start_go(len);
    nb = blocks.size();
    @(negedge clock);
    check("busy_on", 512'(regop_busy), 512'(1));
    check("len_err_clr", 512'(regop_len_err), 512'(0));
    for (int k = 0; k < nb; k++) begin
      wait_rdy(inject && k == 0, n);
      check("latency", 512'(n), 512'(66));
`ifdef PAD_BLK_INFO_EN
      check("blk_idx", 512'(regop_blk_idx), 512'(k));
      check("blk_last", 512'(regop_blk_last), 512'(k == nb - 1));
`endif
      if (len == 3) check("abc_block", regop_pad_reg, {32'h61626380, 416'h0, 64'h18});
      if (len == 0) check("empty_block", regop_pad_reg, {8'h80, 504'h0});
      if (len == 56 && k == 0) check("l56_marker", 512'(regop_pad_reg[511 - 8*56 -: 8]), 512'(8'h80));
      if (len == 56 && k == 1) check("l56_tail", regop_pad_reg, {448'h0, 64'h1C0});
      if (len == 64 && k == 1) check("l64_blk1", regop_pad_reg, {8'h80, 440'h0, 64'h200});
      for (int i = 0; i < ack_delay; i++) begin
        if (inject && i == 1) begin
          main_go_sig = 1'b1;
          msg_len = LEN_W'(7);
        end
        if (inject && i == 2) begin
          main_go_sig = 1'b0;
          msg_len = '0;
        end
        @(negedge clock);
      end
      main_go_sig = 1'b0;
      pad_ack = 1'b1;
      @(posedge clock);
      #1;
      pad_ack = 1'b0;
      mon_idx++;
    end
    @(negedge clock);
    check("done_pulse", 512'(regop_done), 512'(1));
    check("rdy_drop", 512'(regop_pad_rdy), 512'(0));
    @(negedge clock);
    check("done_end", 512'(regop_done), 512'(0));
    check("busy_off", 512'(regop_busy), 512'(0));
    check("rd_count", 512'(exp_next_addr), 512'(len));
    mon_active = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 29 + 5);
    mem[0] = 8'h61;
    mem[1] = 8'h62;
    mem[2] = 8'h63;

    repeat (3) @(negedge clock);
    check("rst_en", 512'(regop_msg_mem_en), 512'(0));
    check("rst_addr", 512'(regop_msg_mem_addr), 512'(0));
    check("rst_pad", regop_pad_reg, 512'(0));
    check("rst_rdy", 512'(regop_pad_rdy), 512'(0));
    check("rst_busy", 512'(regop_busy), 512'(0));
    check("rst_done", 512'(regop_done), 512'(0));
    check("rst_len_err", 512'(regop_len_err), 512'(0));
    reset = 1'b1;

    build_model(3);
    check("model_abc", blocks[0], {32'h61626380, 416'h0, 64'h18});
    build_model(0);
    check("model_empty", blocks[0], {8'h80, 504'h0});
    build_model(55);
    check("model_nb55", 512'(blocks.size()), 512'(1));
    build_model(56);
    check("model_nb56", 512'(blocks.size()), 512'(2));
    build_model(64);
    check("model_nb64", 512'(blocks.size()), 512'(2));
    check("model_l64_blk1", blocks[1], {8'h80, 440'h0, 64'h200});

    run_msg(3, 0, 1'b0);
    run_msg(56, 0, 1'b0);
    run_msg(64, 10, 1'b0);

    // over-length request: no blocks, no reads
    blocks = {};
    exp_len = 0;
    exp_next_addr = 0;
    mon_active = 1'b1;
    @(negedge clock);
    main_go_sig = 1'b1;
    msg_len = LEN_W'(MAX + 1);
    @(negedge clock);
    main_go_sig = 1'b0;
    msg_len = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 0 || i == 19) begin
        check("err_len_err", 512'(regop_len_err), 512'(1));
        check("err_busy", 512'(regop_busy), 512'(0));
        check("err_done", 512'(regop_done), 512'(0));
        check("err_rdy", 512'(regop_pad_rdy), 512'(0));
      end
    end
    mon_active = 1'b0;
    run_msg(0, 0, 1'b0);

    // reset 30 cycles into a len=100 transfer
    start_go(100);
    repeat (30) @(posedge clock);
    #2;
    mon_active = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_en", 512'(regop_msg_mem_en), 512'(0));
    check("abort_addr", 512'(regop_msg_mem_addr), 512'(0));
    check("abort_pad", regop_pad_reg, 512'(0));
    check("abort_busy", 512'(regop_busy), 512'(0));
    check("abort_rdy", 512'(regop_pad_rdy), 512'(0));
    check("abort_done", 512'(regop_done), 512'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("post_abort_done", 512'(regop_done), 512'(0));
      check("post_abort_busy", 512'(regop_busy), 512'(0));
    end
    run_msg(100, 2, 1'b0);

    run_msg(120, 4, 1'b1);
    run_msg(55, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
